// File: rtl/run_detector.sv
// run_detector: serial run-length detector.
// Counts consecutive qualified samples (en=1) whose value equals `target` and
// raises `hit` once the run reaches the threshold `len` (0 is treated as 1).
// mode=0: level/saturating, hit stays high while the run continues.
// mode=1: pulse/non-overlapping, one-cycle hit per completed run of L samples.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   clear           synchronous clear of state and counters
//   en, din         sample qualifier and serial sample
//   target, mode    bit value being counted, level(0)/pulse(1) select
//   len             run threshold
//   hit             detection flag (registered)
//   run_cnt         current run length (registered, saturating)
//   event_cnt       saturating count of detections
//   event_ovf       sticky: detection seen while event_cnt was all-ones
module run_detector #(
    parameter int unsigned LEN_W = 4,
    parameter int unsigned EVT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic             din,
    input  logic             target,
    input  logic             mode,
    input  logic [LEN_W-1:0] len,
    output logic             hit,
    output logic [LEN_W-1:0] run_cnt,
    output logic [EVT_W-1:0] event_cnt,
    output logic             event_ovf
);

    localparam logic [LEN_W-1:0] RUN_MAX = '1;
    localparam logic [EVT_W-1:0] EVT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        MATCH = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             hit_nxt;
    logic [LEN_W-1:0] run_nxt;
    logic [EVT_W-1:0] evt_nxt;
    logic             ovf_nxt;
    logic             det;
    logic [LEN_W-1:0] thr;
    logic [LEN_W-1:0] run_inc;

    // Effective threshold and saturating run increment.
    always_comb begin
        thr     = (len == '0) ? LEN_W'(1) : len;
        run_inc = (run_cnt == RUN_MAX) ? RUN_MAX : run_cnt + LEN_W'(1);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hit       <= 1'b0;
            run_cnt   <= '0;
            event_cnt <= '0;
            event_ovf <= 1'b0;
        end else begin
            state     <= state_nxt;
            hit       <= hit_nxt;
            run_cnt   <= run_nxt;
            event_cnt <= evt_nxt;
            event_ovf <= ovf_nxt;
        end
    end

    // Next-state, next-output and event accounting.
    always_comb begin
        state_nxt = state;
        hit_nxt   = hit;
        run_nxt   = run_cnt;
        evt_nxt   = event_cnt;
        ovf_nxt   = event_ovf;
        det       = 1'b0;

        if (clear) begin
            state_nxt = IDLE;
            hit_nxt   = 1'b0;
            run_nxt   = '0;
            evt_nxt   = '0;
            ovf_nxt   = 1'b0;
        end else if (!en) begin
            // Pulse mode never holds hit across an idle cycle.
            if (mode) begin
                hit_nxt = 1'b0;
            end
        end else if (din != target) begin
            state_nxt = IDLE;
            hit_nxt   = 1'b0;
            run_nxt   = '0;
        end else if (mode) begin
            // A pending MATCH from level mode completes as a pulse.
            if (state == MATCH || run_inc >= thr) begin
                state_nxt = IDLE;
                hit_nxt   = 1'b1;
                run_nxt   = '0;
                det       = 1'b1;
            end else begin
                state_nxt = COUNT;
                hit_nxt   = 1'b0;
                run_nxt   = run_inc;
            end
        end else begin
            // MATCH is sticky against len changes while the run continues.
            if (state == MATCH) begin
                hit_nxt = 1'b1;
                run_nxt = run_inc;
            end else if (run_inc >= thr) begin
                state_nxt = MATCH;
                hit_nxt   = 1'b1;
                run_nxt   = run_inc;
                det       = 1'b1;
            end else begin
                state_nxt = COUNT;
                hit_nxt   = 1'b0;
                run_nxt   = run_inc;
            end
        end

        if (det) begin
            if (event_cnt == EVT_MAX) begin
                ovf_nxt = 1'b1;
            end else begin
                evt_nxt = event_cnt + EVT_W'(1);
            end
        end
    end

endmodule
